// File: rtl/gf_pkg.sv
// Shared constants and helpers for the masked GF(2^W) multiplier.
package gf_pkg;

  // Default reduction polynomials (MSB set, W+1 bits).
  localparam logic [2:0] POLY_GF4   = 3'b111;   // x^2+x+1
  localparam logic [4:0] POLY_GF16  = 5'h13;    // x^4+x+1
  localparam logic [8:0] POLY_GF256 = 9'h11B;   // x^8+x^4+x^3+x+1 (AES)

  // Number of W-bit fresh random words for a given share count.
  function automatic int nr_f(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  // Lexicographic pair index; (i,j) and (j,i) map to the same word.
  function automatic int pair_idx(input int i, input int j, input int shares);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * shares - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/gf_mul_dom_if.sv
// Valid/ready bus carrying shared operands, fresh randomness and product shares.
interface gf_mul_dom_if #(
  parameter int W      = 4,
  parameter int SHARES = 2
);
  localparam int NR = gf_pkg::nr_f(SHARES);

  logic                  in_valid;
  logic                  in_ready;
  logic [SHARES*W-1:0]   a_sh;
  logic [SHARES*W-1:0]   b_sh;
  logic [NR*W-1:0]       rnd;
  logic                  out_valid;
  logic                  out_ready;
  logic [SHARES*W-1:0]   q_sh;

  modport master (
    output in_valid, a_sh, b_sh, rnd, out_ready,
    input  in_ready, out_valid, q_sh
  );

  modport slave (
    input  in_valid, a_sh, b_sh, rnd, out_ready,
    output in_ready, out_valid, q_sh
  );
endinterface

// File: rtl/gf_mul_comb.sv
// Combinational GF(2^W) multiply: carry-less product reduced modulo POLY.
module gf_mul_comb #(
  parameter int         W    = 4,
  parameter logic [W:0] POLY = 5'h13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q
);
  localparam int PW = 2*W - 1;

  logic [PW-1:0] a_x;
  logic [PW-1:0] poly_x;
  logic [PW-1:0] prod;

  assign a_x    = PW'(a);
  assign poly_x = PW'(POLY);

  // Shift-and-XOR product, then fold high bits down from the top.
  always_comb begin
    prod = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) prod = prod ^ (a_x << i);
    for (int d = PW - 1; d >= W; d--)
      if (prod[d]) prod = prod ^ (poly_x << (d - W));
  end

  assign q = prod[W-1:0];
endmodule

// File: rtl/gf_mul_dom.sv
// Two-stage DOM-indep masked GF(2^W) multiplier with valid/ready flow control.
// Stage 1 registers every share-product term (cross terms remasked) so no
// cross term is combined with others before a register; stage 2 compresses
// each row into one output share.
module gf_mul_dom
  import gf_pkg::*;
#(
  parameter int         W      = 4,
  parameter logic [W:0] POLY   = 5'h13,
  parameter int         SHARES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  gf_mul_dom_if.slave   bus
);
  localparam int STAGES = 2;

  logic [SHARES-1:0][SHARES-1:0][W-1:0] prod;
  logic [SHARES-1:0][SHARES-1:0][W-1:0] mask;
  logic [SHARES-1:0][SHARES-1:0][W-1:0] t_d, t_q;
  logic [SHARES-1:0][W-1:0]             q_d, q_q;
  logic [STAGES:1]                      vld_pipe_d, vld_pipe_q;

  logic s2_free, s1_adv, accept;

  // Per-term multipliers and the fresh mask each cross term receives.
  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      gf_mul_comb #(.W(W), .POLY(POLY)) u_mul (
        .a (bus.a_sh[i*W +: W]),
        .b (bus.b_sh[j*W +: W]),
        .q (prod[i][j])
      );
      if (i == j) begin : g_inner
        assign mask[i][j] = '0;
      end else begin : g_cross
        localparam int K = pair_idx(i, j, SHARES);
        assign mask[i][j] = bus.rnd[K*W +: W];
      end
    end
  end

  assign s2_free      = !vld_pipe_q[2] || bus.out_ready;
  assign s1_adv       = vld_pipe_q[1] && s2_free;
  assign bus.in_ready = !vld_pipe_q[1] || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // Next-state: load terms on accept, compress rows on advance, track valids.
  always_comb begin
    t_d        = t_q;
    q_d        = q_q;
    vld_pipe_d = vld_pipe_q;
    if (accept) begin
      for (int i = 0; i < SHARES; i++)
        for (int j = 0; j < SHARES; j++)
          t_d[i][j] = prod[i][j] ^ mask[i][j];
    end
    if (s1_adv) begin
      for (int i = 0; i < SHARES; i++) begin
        q_d[i] = '0;
        for (int j = 0; j < SHARES; j++)
          q_d[i] = q_d[i] ^ t_q[i][j];
      end
    end
    vld_pipe_d[1] = accept || (vld_pipe_q[1] && !s1_adv);
    vld_pipe_d[2] = s1_adv || (vld_pipe_q[2] && !bus.out_ready);
  end

  // Pipeline registers; reset discards any in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q        <= '0;
      q_q        <= '0;
      vld_pipe_q <= '0;
    end else begin
      t_q        <= t_d;
      q_q        <= q_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.q_sh      = q_q;
endmodule

// File: tb/tb_gf_mul_dom.sv
// Directed self-checking bench for the masked GF multiplier.
module tb_gf_mul_dom;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gf_mul_dom_if #(.W(4), .SHARES(2)) bus ();
  gf_mul_dom_if #(.W(8), .SHARES(3)) bus3 ();

  gf_mul_dom #(.W(4), .POLY(5'h13), .SHARES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  gf_mul_dom #(.W(8), .POLY(9'h11B), .SHARES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  logic [1:0] w2_a, w2_b, w2_q;
  gf_mul_comb #(.W(2), .POLY(3'b111)) u_w2 (.a(w2_a), .b(w2_b), .q(w2_q));

  // Reference GF(2^4) product via repeated multiply-by-x.
  function automatic logic [3:0] ref16(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, x;
    r = 4'h0; x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [3:0] r);
    bus.a_sh = a; bus.b_sh = b; bus.rnd = r; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.a_sh = 0; bus.b_sh = 0; bus.rnd = 0; bus.out_ready = 1;
    bus3.in_valid = 0; bus3.a_sh = 0; bus3.b_sh = 0; bus3.rnd = 0; bus3.out_ready = 1;
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.q_sh !== 8'h00) begin
      n_fail++; $display("FAIL reset_hold: out_valid=%b q_sh=%h want 0/00", bus.out_valid, bus.q_sh);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_concrete();
    beat({4'h0, 4'h2}, {4'h0, 4'h8}, 4'h0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL concrete_latency1: out_valid=%b want 0", bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.q_sh !== 8'h03) begin
      n_fail++; $display("FAIL concrete: out_valid=%b q_sh=%h want 1/03", bus.out_valid, bus.q_sh);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL concrete_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_fresh_rnd();
    beat({4'h0, 4'h2}, {4'h0, 4'h8}, 4'h9);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.q_sh !== 8'h9A) begin
      n_fail++; $display("FAIL fresh_rnd: out_valid=%b q_sh=%h want 1/9a", bus.out_valid, bus.q_sh);
    end
    tick();
  endtask

  task automatic test_reduction();
    logic [3:0] a, b, ma, mb, r, got;
    int bad;
    beat({4'h7, 4'hF}, {4'h9, 4'h1}, 4'h5);
    tick();
    got = bus.q_sh[7:4] ^ bus.q_sh[3:0];
    n_checks++;
    if (bus.out_valid !== 1'b1 || got !== 4'hC) begin
      n_fail++; $display("FAIL reduction_8x8: out_valid=%b xor=%h want 1/c", bus.out_valid, got);
    end
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 4'($urandom); b = 4'($urandom); ma = 4'($urandom); mb = 4'($urandom); r = 4'($urandom);
      beat({ma, a ^ ma}, {mb, b ^ mb}, r);
      tick();
      got = bus.q_sh[7:4] ^ bus.q_sh[3:0];
      n_checks++;
      if (bus.out_valid !== 1'b1 || got !== ref16(a, b)) begin
        n_fail++;
        if (bad < 5) $display("FAIL random_split a=%h b=%h r=%h: xor=%h want %h", a, b, r, got, ref16(a, b));
        bad++;
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] bv [6];
    logic [3:0] exp_q [6];
    logic [3:0] got;
    int idx, nout, last_cyc;
    bv    = '{4'h1, 4'h8, 4'h9, 4'hF, 4'h5, 4'hC};
    exp_q = '{4'h2, 4'h3, 4'h1, 4'hD, 4'hA, 4'hB};
    idx = 0; nout = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (idx < 6);
      if (idx < 6) begin
        bus.a_sh = {4'(idx + 3), 4'h2 ^ 4'(idx + 3)};
        bus.b_sh = {4'(idx * 5), bv[idx] ^ 4'(idx * 5)};
        bus.rnd  = 4'(idx);
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        n_checks++;
        if (bus.in_ready !== 1'b0 || idx !== 2) begin
          n_fail++; $display("FAIL bp_stall cyc=%0d: in_ready=%b accepted=%0d want 0/2", cyc, bus.in_ready, idx);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        got = bus.q_sh[7:4] ^ bus.q_sh[3:0];
        n_checks++;
        if (nout >= 6 || got !== exp_q[nout] || (last_cyc >= 0 && cyc != last_cyc + 1)) begin
          n_fail++;
          $display("FAIL bp_out #%0d cyc=%0d: xor=%h want %h (prev cyc %0d)", nout, cyc, got,
                   (nout < 6) ? exp_q[nout] : 4'h0, last_cyc);
        end
        nout++; last_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    n_checks++;
    if (nout !== 6) begin
      n_fail++; $display("FAIL bp_count: outputs=%0d want 6", nout);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 0;
    bus.a_sh = {4'h0, 4'h2}; bus.b_sh = {4'h0, 4'h8}; bus.rnd = 4'h0; bus.in_valid = 1;
    tick(); tick();
    bus.in_valid = 0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.q_sh !== 8'h03) begin
      n_fail++; $display("FAIL mid_prefill: out_valid=%b in_ready=%b q_sh=%h want 1/0/03",
                         bus.out_valid, bus.in_ready, bus.q_sh);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.q_sh !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset: out_valid=%b q_sh=%h want 0/00", bus.out_valid, bus.q_sh);
    end
    bus.out_ready = 1;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_ghost: out_valid=%b want 0", bus.out_valid);
    end
    beat({4'h0, 4'h8}, {4'h0, 4'h8}, 4'h0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_latency1: out_valid=%b want 0", bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.q_sh !== 8'h0C) begin
      n_fail++; $display("FAIL mid_after: out_valid=%b q_sh=%h want 1/0c", bus.out_valid, bus.q_sh);
    end
    tick();
  endtask

  task automatic test_shares3();
    logic [7:0] ma1, ma2, mb1, mb2, got;
    for (int n = 0; n < 6; n++) begin
      ma1 = 8'($urandom); ma2 = 8'($urandom); mb1 = 8'($urandom); mb2 = 8'($urandom);
      bus3.a_sh = {ma2, ma1, 8'h57 ^ ma1 ^ ma2};
      bus3.b_sh = {mb2, mb1, 8'h83 ^ mb1 ^ mb2};
      bus3.rnd  = 24'($urandom);
      bus3.in_valid = 1;
      tick();
      bus3.in_valid = 0;
      tick();
      got = bus3.q_sh[23:16] ^ bus3.q_sh[15:8] ^ bus3.q_sh[7:0];
      n_checks++;
      if (bus3.out_valid !== 1'b1 || got !== 8'hC1) begin
        n_fail++; $display("FAIL shares3 #%0d: out_valid=%b xor=%h want 1/c1", n, bus3.out_valid, got);
      end
    end
    tick();
  endtask

  task automatic test_w2_sweep();
    logic [1:0] tbl [16];
    tbl = '{2'd0, 2'd0, 2'd0, 2'd0,
            2'd0, 2'd1, 2'd2, 2'd3,
            2'd0, 2'd2, 2'd3, 2'd1,
            2'd0, 2'd3, 2'd1, 2'd2};
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        w2_a = 2'(a); w2_b = 2'(b);
        #1;
        n_checks++;
        if (w2_q !== tbl[a*4 + b]) begin
          n_fail++; $display("FAIL w2 %0d*%0d: got %0d want %0d", a, b, w2_q, tbl[a*4 + b]);
        end
      end
  endtask

  initial begin
    w2_a = 0; w2_b = 0;
    test_reset();
    test_concrete();
    test_fresh_rnd();
    test_reduction();
    test_backpressure();
    test_reset_midstream();
    test_shares3();
    test_w2_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
